mem_responder: RTL
==================

// Module: mem_responder
//
// PURPOSE
//  Single-port, SRAM-backed responder for one core memory interface (imem or
//  dmem) using the core's req/gnt protocol. Accepts one request at a time,
//  waits a programmable latency, then grants with read data or error. It is
//  the target-side counterpart to the core's initiator ports. It backs the
//  core in formal and simulation benches, so RVFI/design assertions observe a
//  real responder.
//
// PARAMETERS
//  DEPTH_W    10     log2 of memory depth in 64-bit words
//  BASE_ADDR  64'h0  byte address of word 0
//  LATENCY    1      wait cycles before grant; legal range 1..15
//  ROM_BYTES  0      bytes from BASE_ADDR that are read-only; 0 = none
//
// PORTS
//  clock      in   1   core clock
//  g_resetn   in   1   asynchronous active-low reset
//  mem_req    in   1   request; held stable with all fields until mem_gnt
//  mem_rtype  in   1   request type I/D; informational, not decoded
//  mem_addr   in   64  byte address; bits [2:0] ignored
//  mem_wen    in   1   1 = write, 0 = read
//  mem_strb   in   8   write byte strobes; bit n enables wdata[8n+7:8n]
//  mem_wdata  in   64  write data
//  mem_prv    in   2   privilege level; informational, not decoded
//  mem_gnt    out  1   one-cycle grant; response valid this cycle
//  mem_err    out  1   error response; qualified by mem_gnt
//  mem_rdata  out  64  read data; qualified by mem_gnt
//  rsp_stall  in   1   bench back-pressure; holds the FSM in WAIT
//  busy       out  1   high whenever the FSM is not in IDLE
//
// BEHAVIOUR
//  - Reset state: FSM in IDLE; mem_gnt=0, mem_err=0, mem_rdata=0, busy=0.
//    Memory array is not reset.
//  - FSM states: IDLE, WAIT, GNT.
//  - IDLE, mem_req=1:
//    . capture addr, wen, strb, wdata;
//    . load wait counter with LATENCY-1;
//    . go to WAIT.
//  - WAIT, counter!=0: decrement. rsp_stall does not freeze the count.
//  - WAIT, counter==0, rsp_stall=0:
//    . perform the access;
//    . register mem_rdata and mem_err;
//    . go to GNT.
//  - WAIT, counter==0, rsp_stall=1: stay in WAIT.
//  - GNT: mem_gnt=1 for exactly one cycle, then go to IDLE unconditionally.
//    . The IDLE bubble is mandatory. mem_req is still the old request in GNT.
//  - Latency: mem_gnt rises LATENCY+1 cycles after the IDLE cycle sampling
//    mem_req, plus one cycle per cycle spent in WAIT with counter==0 and
//    rsp_stall=1.
//  - Back-to-back: minimum request spacing is LATENCY+2 cycles.
//  - Address decode: off = addr - BASE_ADDR (64-bit, wraps); idx = off[..:3].
//  - Error when either holds:
//    . off >= 8<<DEPTH_W (this covers addr < BASE_ADDR via wrap);
//    . wen=1 and off < ROM_BYTES.
//  - On error: no array write; mem_rdata=0; mem_err=1.
//  - Read: mem_rdata = mem[idx].
//  - Write: bytes with strb=1 are updated; mem_rdata=0 on writes.
//  - mem_rdata and mem_err are 0 in every cycle where mem_gnt=0.
//  - The write commits on the WAIT->GNT edge only.
//  - Reset mid-operation: returns to IDLE with outputs 0. A write that has
//    not reached GNT is discarded.
//  - mem_req dropped during WAIT violates the protocol. The responder still
//    completes the captured request and issues mem_gnt.
//
// TESTING
//  1. LATENCY=2; write BASE+0x10, strb=8'hFF, wdata=64'h1122334455667788
//     -> gnt 3 cycles after req, err=0.
//     Read BASE+0x10 -> rdata=64'h1122334455667788.
//  2. Then write BASE+0x10, strb=8'h0F, wdata=64'hAAAAAAAABBBBBBBB.
//     Read it back -> rdata=64'h11223344BBBBBBBB.
//  3. Read BASE+(8<<DEPTH_W) and read BASE-8 -> gnt with err=1, rdata=0.
//     A write to the same out-of-range address leaves the array unchanged.
//  4. LATENCY=1; rsp_stall=1 for 3 cycles once counter==0 -> gnt 2+3=5
//     cycles after req.
//     Then busy falls, and a new req is accepted on the next IDLE cycle.
//  5. ROM_BYTES=0x100; write BASE+0x8 -> err=1, word unchanged.
//     Read BASE+0x8 -> err=0. Write BASE+0x100 -> err=0.
//  6. g_resetn low during WAIT of a write -> gnt/busy/rdata 0 asynchronously.
//     Later read of that address returns its pre-write value.

Source files
------------

// File: rtl/mem_responder.sv
// SRAM-backed target for the core req/gnt memory protocol: one request at a
// time, a programmable wait, then a single-cycle grant carrying data or error.
module mem_responder #(
  parameter int unsigned DEPTH_W   = 10,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned LATENCY   = 1,
  parameter logic [63:0] ROM_BYTES = 64'h0
) (
  input  logic        clock,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic        mem_rtype,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [7:0]  mem_strb,
  input  logic [63:0] mem_wdata,
  input  logic [1:0]  mem_prv,
  output logic        mem_gnt,
  output logic        mem_err,
  output logic [63:0] mem_rdata,
  input  logic        rsp_stall,
  output logic        busy
);

  localparam int unsigned DEPTH  = 1 << DEPTH_W;
  localparam logic [63:0] SPAN   = 64'd8 << DEPTH_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GNT  = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [63:0]         addr_r;
  logic                wen_r;
  logic [7:0]          strb_r;
  logic [63:0]         wdata_r;
  logic                gnt_r;
  logic                err_r;
  logic [63:0]         rdata_r;
  logic                busy_r;
  logic                fire_s;
  logic                err_s;
  logic [63:0]         off_s;
  logic [DEPTH_W-1:0]  idx_s;
  logic [63:0]         mem_r [0:DEPTH-1];
  logic                unused_s;

  // Offsets below BASE_ADDR wrap to huge values, so one range check covers both ends.
  assign off_s    = addr_r - BASE_ADDR;
  assign idx_s    = off_s[DEPTH_W+2:3];
  assign err_s    = (off_s >= SPAN) || (wen_r && (off_s < ROM_BYTES));
  assign unused_s = ^{mem_rtype, mem_prv};

  // Next-state decode; fire_s marks the single cycle the access is performed.
  always_comb begin
    state_nxt_s = state_r;
    fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_req) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if ((cnt_r == 4'd0) && !rsp_stall) begin
          fire_s      = 1'b1;
          state_nxt_s = ST_GNT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GNT:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, request capture, wait counter and registered response outputs.
  always_ff @(posedge clock or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 64'd0;
      wen_r   <= 1'b0;
      strb_r  <= 8'd0;
      wdata_r <= 64'd0;
      gnt_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 64'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= (state_nxt_s == ST_GNT);
      busy_r  <= (state_nxt_s != ST_IDLE);
      if ((state_r == ST_IDLE) && mem_req) begin
        addr_r  <= mem_addr;
        wen_r   <= mem_wen;
        strb_r  <= mem_strb;
        wdata_r <= mem_wdata;
        cnt_r   <= LAT_M1;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      // Response fields are nonzero only while the grant is up.
      if (fire_s) begin
        err_r   <= err_s;
        rdata_r <= (err_s || wen_r) ? 64'd0 : mem_r[idx_s];
      end else if (state_r == ST_GNT) begin
        err_r   <= 1'b0;
        rdata_r <= 64'd0;
      end else begin
        err_r   <= err_r;
        rdata_r <= rdata_r;
      end
    end
  end

  // Byte-lane write on the commit edge only; the array itself is not reset.
  always_ff @(posedge clock) begin
    if (fire_s && wen_r && !err_s) begin
      for (int b = 0; b < 8; b++) begin
        if (strb_r[b]) begin
          mem_r[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  assign mem_gnt   = gnt_r;
  assign mem_err   = err_r;
  assign mem_rdata = rdata_r;
  assign busy      = busy_r;

endmodule
